// File: rtl/ski_pkg.sv
// Shared definitions for the SKI heap controller: field widths, bit positions,
// response kinds and the request/response layouts.
package ski_pkg;

    localparam int PTR_W  = 30;
    localparam int WORD_W = 64;
    localparam int CNT_W  = 16;

    localparam int REQ_W = 2 + PTR_W + WORD_W;
    localparam int RSP_W = 2 + WORD_W;

    localparam int REQ_VALID_BIT = 95;
    localparam int REQ_WRITE_BIT = 94;
    localparam int REQ_PTR_MSB   = 93;
    localparam int REQ_PTR_LSB   = 64;
    localparam int REQ_DATA_MSB  = 63;
    localparam int RSP_VALID_BIT = 65;
    localparam int RSP_KIND_BIT  = 64;
    localparam int RSP_WORD_MSB  = 63;

    localparam logic KIND_READ = 1'b0;
    localparam logic KIND_WACK = 1'b1;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    // Field order matches the bit positions above (MSB first).
    typedef struct packed {
        logic              valid;
        logic              write;
        logic [PTR_W-1:0]  ptr;
        logic [WORD_W-1:0] data;
    } req_t;

    typedef struct packed {
        logic              valid;
        logic              kind;
        logic [WORD_W-1:0] word;
    } rsp_t;

    function automatic logic ptr_out_of_range(input logic [PTR_W-1:0] ptr,
                                              input int               addr_w);
        return (addr_w < PTR_W) ? |(ptr >> addr_w) : 1'b0;
    endfunction

endpackage

// File: rtl/ski_heap_mem.sv
// Single-port synchronous heap RAM, 2^ADDR_W x 64, write enable, registered
// read-first output.
module ski_heap_mem
    import ski_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    // NOTE: the array has no reset so it maps onto RAM macros; contents
    // survive reset and are cleared only by the optional init sweep.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ski_heap_ctrl.sv
// Heap request controller: one request per cycle, 1-cycle response, range
// checking with a saturating error counter. Define HEAP_RAM_ZERO_INIT_EN to
// zero the heap after every reset before accepting requests.
module ski_heap_ctrl
    import ski_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic             system1000,
    input  logic             system1000_rst,
    input  logic [REQ_W-1:0] req_i,
    output logic             req_ready_o,
    output logic [RSP_W-1:0] rsp_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o
);

`ifdef HEAP_RAM_ZERO_INIT_EN
    localparam state_t RESET_STATE = ST_INIT;
`else
    localparam state_t RESET_STATE = ST_READY;
`endif

    req_t              req;
    logic              oor;
    logic              ready;
    logic              accept;
    state_t            state_q;
    state_t            state_d;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;

    logic              rsp_valid_q;
    logic              rsp_kind_q;
    logic              rsp_err_q;
    logic [CNT_W-1:0]  err_cnt_q;
    rsp_t              rsp;

`ifdef HEAP_RAM_ZERO_INIT_EN
    logic [ADDR_W-1:0] init_addr_q;
    logic [ADDR_W-1:0] init_addr_d;
`endif

    assign req    = req_t'(req_i);
    assign oor    = ptr_out_of_range(req.ptr, ADDR_W);
    assign accept = req.valid && ready;

    // NOTE: every signal driven here gets a default first so no path through
    // the case leaves it unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = req.ptr[ADDR_W-1:0];
        mem_wdata = req.data;
`ifdef HEAP_RAM_ZERO_INIT_EN
        init_addr_d = init_addr_q;
`endif
        case (state_q)
            ST_INIT: begin
`ifdef HEAP_RAM_ZERO_INIT_EN
                // The sweep owns the RAM port; READY follows the last write.
                mem_en      = 1'b1;
                mem_we      = 1'b1;
                mem_addr    = init_addr_q;
                mem_wdata   = '0;
                init_addr_d = init_addr_q + 1'b1;
                if (init_addr_q == '1) begin
                    state_d = ST_READY;
                end
`else
                state_d = ST_READY;
`endif
            end
            ST_READY: begin
                ready = 1'b1;
                if (req.valid && !oor) begin
                    mem_en = 1'b1;
                    mem_we = req.write;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            state_q     <= RESET_STATE;
            rsp_valid_q <= 1'b0;
            rsp_kind_q  <= KIND_READ;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= accept;
            rsp_kind_q  <= accept ? req.write : KIND_READ;
            rsp_err_q   <= accept && oor;
            if (accept && oor && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

`ifdef HEAP_RAM_ZERO_INIT_EN
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            init_addr_q <= '0;
        end else begin
            init_addr_q <= init_addr_d;
        end
    end
`endif

    ski_heap_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (system1000),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Data is only exposed for in-range reads; acks and errors carry zero.
    assign rsp.valid = rsp_valid_q;
    assign rsp.kind  = rsp_kind_q;
    assign rsp.word  = (rsp_valid_q && (rsp_kind_q == KIND_READ) && !rsp_err_q)
                       ? mem_rdata : '0;

    assign rsp_o       = rsp;
    assign err_o       = rsp_valid_q && rsp_err_q;
    assign err_cnt_o   = err_cnt_q;
    assign req_ready_o = ready;

endmodule

// File: doc/ski_heap_ctrl.md
SKI_HEAP_CTRL -- requirements
Module: ski_heap_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 10, log2 of heap depth in 64-bit words (heap depth 2^ADDR_W).
REQ-002 Port: system1000  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: system1000_rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: req_i  input  96  CPU request: [95] valid, [94] write(1)/read(0), [93:64] ptr (30 bits), [63:0] write data.
REQ-005 Port: req_ready_o  output  1  request accepted on any edge where req_i[95] and req_ready_o are both high.
REQ-006 Port: rsp_o  output  66  response: [65] valid, [64] kind (0 read data, 1 write ack), [63:0] word.
REQ-007 Port: err_o  output  1  one-cycle pulse, aligned with rsp_o[65], for an out-of-range pointer.
REQ-008 Port: err_cnt_o  output  16  saturating count of out-of-range requests.

Function
REQ-009 States: INIT, READY. req_ready_o is high only in READY.
REQ-010 Throughput: READY accepts one request per cycle, back to back, with no bubbles.
REQ-011 Latency: exactly 1 cycle; an accepted request yields rsp_o[65]=1 for exactly one cycle on the following cycle. No response path backpressure.
REQ-012 Read: rsp_o = {1,0,mem[ptr[ADDR_W-1:0]]}.
REQ-013 Write: mem[ptr] <= data at the accept edge; rsp_o = {1,1,64'h0}.
REQ-014 Read-after-write to the same ptr on the next cycle returns the newly written data.
REQ-015 Out of range (ptr >= 2^ADDR_W):
- no memory access;
- rsp_o = {1,kind,64'h0};
- err_o=1 in the response cycle;
- err_cnt_o increments, saturating at 16'hFFFF.
REQ-016 Cycles with no accepted request: rsp_o = 66'h0 and err_o=0.
REQ-017 Requests presented in INIT are not accepted, not queued, and produce no response; the requester holds them.
REQ-018 Fields [94:0] of req_i are ignored when req_i[95]=0.

Reset
REQ-019 Reset values: rsp_o=0, err_o=0, err_cnt_o=0.
REQ-020 Reset entry state: INIT if HEAP_RAM_ZERO_INIT_EN is defined, else READY.
REQ-021 Reset mid-operation: any pending response is discarded and never emitted. Reset mid-INIT restarts the sweep at address 0.
REQ-022 Heap contents are not altered by reset itself.

Configuration
REQ-023 Macro HEAP_RAM_ZERO_INIT_EN defined:
- INIT sweeps an ADDR_W-bit counter from 0 to 2^ADDR_W-1;
- writes 64'h0 to one address per cycle;
- enters READY on the cycle after the last write (req_ready_o low for exactly 2^ADDR_W cycles after reset release).
REQ-024 HEAP_RAM_ZERO_INIT_EN undefined: no sweep logic exists, READY follows reset immediately, and heap contents are undefined until written.

Structure
REQ-025 Shared package ski_pkg holds:
- field widths (PTR_W=30, WORD_W=64);
- request/response bit-position constants;
- kind encodings (KIND_READ=0, KIND_WACK=1).
REQ-026 One sub-module, ski_heap_mem: single-port synchronous 2^ADDR_W x 64 RAM with write enable and registered read. The init sweep and request path share its single port via a mux.

Verification
REQ-027 Write ptr=5, data=64'hDEAD_BEEF_0000_0001; read ptr=5 on the next cycle -> ack {1,1,0}, then {1,0,64'hDEAD_BEEF_0000_0001}.
REQ-028 Reads of ptr 0..7 on 8 consecutive cycles after writing 0..7 with value=ptr -> 8 consecutive responses carrying 0..7, req_ready_o constantly high.
REQ-029 Read ptr=30'h3FF_FFFF (ADDR_W=10) -> rsp_o={1,0,0}, err_o=1, err_cnt_o=1; heap unchanged.
REQ-030 With HEAP_RAM_ZERO_INIT_EN: reset release with a read held on ptr=3 -> req_ready_o low 1024 cycles, then read accepted, returning 0.
REQ-031 Assert reset in the cycle after accepting a read -> rsp_o[65] stays 0 and no response is ever emitted for it.
REQ-032 Force err_cnt_o to 16'hFFFF via repeated out-of-range requests, then issue one more -> err_cnt_o stays 16'hFFFF and err_o still pulses.
